// File: rtl/if_id_stage_if.sv
// ----------------------------------------------------------------------------
// if_id_stage_if
// Bundles the signals between fetch / EX and the IF/ID stage of the LEGv8
// pipeline.
//
//   master : fetch/EX side. Drives the fetched PC/instruction, branch flush,
//            external stall and EX load info. Observes the ID-side outputs.
//   slave  : the IF/ID stage itself.
//
// Signals
//   if_pc, if_instr        fetched PC and instruction for this cycle
//   br_taken               taken branch, flush IF/ID
//   ext_stall              external request to hold IF/ID
//   ex_mem_read, ex_rd     the instruction in EX is a load, and its destination
//   id_pc, id_instr        registered PC and instruction
//   id_valid               IF/ID holds a real instruction
//   id_rn, id_rm           source register fields of id_instr
//   id_bubble              ID/EX must load a NOP this cycle
//   pc_write               enable for the fetch PC register
//   hazard_count           saturating count of load-use stall cycles
// ----------------------------------------------------------------------------
interface if_id_stage_if #(
    parameter int ADDR_W  = 64,
    parameter int INSTR_W = 32,
    parameter int CNT_W   = 16
);
    logic [ADDR_W-1:0]  if_pc;
    logic [INSTR_W-1:0] if_instr;
    logic               br_taken;
    logic               ext_stall;
    logic               ex_mem_read;
    logic [4:0]         ex_rd;
    logic [ADDR_W-1:0]  id_pc;
    logic [INSTR_W-1:0] id_instr;
    logic               id_valid;
    logic [4:0]         id_rn;
    logic [4:0]         id_rm;
    logic               id_bubble;
    logic               pc_write;
    logic [CNT_W-1:0]   hazard_count;

    modport master (
        output if_pc, if_instr, br_taken, ext_stall, ex_mem_read, ex_rd,
        input  id_pc, id_instr, id_valid, id_rn, id_rm, id_bubble, pc_write, hazard_count
    );

    modport slave (
        input  if_pc, if_instr, br_taken, ext_stall, ex_mem_read, ex_rd,
        output id_pc, id_instr, id_valid, id_rn, id_rm, id_bubble, pc_write, hazard_count
    );
endinterface

// File: rtl/if_id_stage.sv
// ----------------------------------------------------------------------------
// if_id_stage
// IF/ID pipeline register and load-use hazard unit for the pipelined LEGv8
// CPU. It captures the fetched PC and instruction one cycle after fetch. It
// extracts the source register fields and detects load-use hazards against
// the instruction in EX. From that it drives the fetch PC write enable. A
// taken branch flushes the stage. A saturating counter records hazard-stall
// cycles for performance debug.
//
// Ports
//   i_clk    clock, all state updates on the rising edge
//   i_reset  synchronous, active-high reset
//   bus      if_id_stage_if slave modport (fetch/EX inputs, ID outputs)
// ----------------------------------------------------------------------------
module if_id_stage #(
    parameter int ADDR_W  = 64,
    parameter int INSTR_W = 32,
    parameter int CNT_W   = 16
) (
    input  logic         i_clk,
    input  logic         i_reset,
    if_id_stage_if.slave bus
);
    localparam logic [4:0] XZR = 5'd31;

    logic [ADDR_W-1:0]  r_pc;
    logic [INSTR_W-1:0] r_instr;
    logic               r_valid;
    logic [CNT_W-1:0]   r_hazard_cnt;

    logic [10:0] w_op11;
    logic        w_rtype;
    logic        w_addi;
    logic        w_ldur;
    logic        w_stur;
    logic        w_cbz;
    logic        w_use_rn;
    logic        w_use_rm;
    logic [4:0]  w_rn;
    logic [4:0]  w_rm;
    logic        w_hazard;
    logic        w_stall;
    logic        w_cnt_full;

    // Classify the instruction held in ID and pick its source register fields
    always_comb begin
        w_op11 = r_instr[31:21];
        case (w_op11)
            11'b10101011000,                  // ADDS
            11'b11101011000,                  // SUBS
            11'b10001010000,                  // AND
            11'b10101010000,                  // ORR
            11'b11001010000: w_rtype = 1'b1;  // EOR
            default:         w_rtype = 1'b0;
        endcase
        w_addi   = (r_instr[31:22] == 10'b1001000100);
        w_ldur   = (w_op11 == 11'b11111000010);
        w_stur   = (w_op11 == 11'b11111000000);
        w_cbz    = (r_instr[31:24] == 8'b10110100);
        w_use_rn = w_rtype | w_addi | w_ldur | w_stur;
        // STUR and CBZ read their Rt through the [4:0] field.
        w_use_rm = w_rtype | w_stur | w_cbz;
        w_rn     = r_instr[9:5];
        if (w_rtype) begin
            w_rm = r_instr[20:16];
        end else begin
            w_rm = r_instr[4:0];
        end
    end

    // Load-use hazard against EX. XZR is never a real dependency.
    always_comb begin
        if (r_valid && bus.ex_mem_read && (bus.ex_rd != XZR)) begin
            w_hazard = (w_use_rn && (bus.ex_rd == w_rn)) ||
                       (w_use_rm && (bus.ex_rd == w_rm));
        end else begin
            w_hazard = 1'b0;
        end
        w_stall    = w_hazard | bus.ext_stall;
        w_cnt_full = &r_hazard_cnt;
    end

    // IF/ID pipeline register: flush beats stall, stall beats advance
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_pc    <= '0;
            r_instr <= '0;
            r_valid <= 1'b0;
        end else if (bus.br_taken) begin
            r_instr <= '0;
            r_valid <= 1'b0;
        end else if (!w_stall) begin
            r_pc    <= bus.if_pc;
            r_instr <= bus.if_instr;
            r_valid <= 1'b1;
        end
    end

    // Saturating count of load-use stall cycles. A flushing edge is not counted.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_hazard_cnt <= '0;
        end else if (w_hazard && !bus.br_taken && !w_cnt_full) begin
            r_hazard_cnt <= r_hazard_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign bus.id_pc        = r_pc;
    assign bus.id_instr     = r_instr;
    assign bus.id_valid     = r_valid;
    assign bus.id_rn        = w_rn;
    assign bus.id_rm        = w_rm;
    assign bus.id_bubble    = ~r_valid | w_hazard;
    // A taken branch always reloads the PC, even when ID is stalled.
    assign bus.pc_write     = bus.br_taken | ~w_stall;
    assign bus.hazard_count = r_hazard_cnt;
endmodule

// File: tb/tb_if_id_stage.sv
module tb_if_id_stage;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        t_reset;
    logic [63:0] t_pc;
    logic [31:0] t_instr;
    logic        t_br;
    logic        t_es;
    logic        t_mr;
    logic [4:0]  t_rd;

    if_id_stage_if #(.ADDR_W(64), .INSTR_W(32), .CNT_W(16)) bus16 ();
    if_id_stage_if #(.ADDR_W(64), .INSTR_W(32), .CNT_W(4))  bus4 ();

    assign bus16.if_pc       = t_pc;
    assign bus16.if_instr    = t_instr;
    assign bus16.br_taken    = t_br;
    assign bus16.ext_stall   = t_es;
    assign bus16.ex_mem_read = t_mr;
    assign bus16.ex_rd       = t_rd;
    assign bus4.if_pc        = t_pc;
    assign bus4.if_instr     = t_instr;
    assign bus4.br_taken     = t_br;
    assign bus4.ext_stall    = t_es;
    assign bus4.ex_mem_read  = t_mr;
    assign bus4.ex_rd        = t_rd;

    if_id_stage #(.ADDR_W(64), .INSTR_W(32), .CNT_W(16)) u_dut (
        .i_clk   (clk),
        .i_reset (t_reset),
        .bus     (bus16)
    );

    if_id_stage #(.ADDR_W(64), .INSTR_W(32), .CNT_W(4)) u_dut4 (
        .i_clk   (clk),
        .i_reset (t_reset),
        .bus     (bus4)
    );

    int tests = 0;
    int fails = 0;

    // reference model state
    logic [63:0] m_pc;
    logic [31:0] m_instr;
    bit          m_valid;
    int          m_cnt;
    int          m_cnt4;

    localparam logic [31:0] ADDS_X1 = 32'hAB030041;
    localparam logic [31:0] CBZ_X5  = 32'hB4000005;
    localparam logic [31:0] B_3     = 32'h14000003;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reads the source registers an instruction uses from its opcode class.
    function automatic void m_decode(input logic [31:0] ins, output bit use_rn, output bit use_rm,
                                     output logic [4:0] rn, output logic [4:0] rm);
        int unsigned op11;
        bit r, addi, ldur, stur, cbz;
        op11   = ins >> 21;
        r      = op11 inside {11'b10101011000, 11'b11101011000, 11'b10001010000,
                              11'b10101010000, 11'b11001010000};
        addi   = (ins >> 22) == 32'b1001000100;
        ldur   = op11 == 32'b11111000010;
        stur   = op11 == 32'b11111000000;
        cbz    = (ins >> 24) == 32'b10110100;
        use_rn = r || addi || ldur || stur;
        use_rm = r || stur || cbz;
        rn     = 5'((ins >> 5) % 32);
        rm     = r ? 5'((ins >> 16) % 32) : 5'(ins % 32);
    endfunction

    // Check all outputs against the model, then clock one edge and advance the model.
    task automatic step();
        bit urn, urm, hz;
        logic [4:0] rn, rm;
        #1;
        m_decode(m_instr, urn, urm, rn, rm);
        hz = m_valid && t_mr && (t_rd != 5'd31) && ((urn && t_rd == rn) || (urm && t_rd == rm));
        chk("id_pc",     bus16.id_pc, m_pc);
        chk("id_instr",  64'(bus16.id_instr), 64'(m_instr));
        chk("id_valid",  64'(bus16.id_valid), 64'(m_valid));
        chk("id_rn",     64'(bus16.id_rn), 64'(rn));
        chk("id_rm",     64'(bus16.id_rm), 64'(rm));
        chk("id_bubble", 64'(bus16.id_bubble), 64'(!m_valid || hz));
        chk("pc_write",  64'(bus16.pc_write), 64'(t_br || !(hz || t_es)));
        chk("cnt16",     64'(bus16.hazard_count), 64'(m_cnt));
        chk("cnt4",      64'(bus4.hazard_count), 64'(m_cnt4));
        @(posedge clk);
        if (t_reset) begin
            m_pc = '0; m_instr = '0; m_valid = 0; m_cnt = 0; m_cnt4 = 0;
        end else begin
            if (hz && !t_br) begin
                if (m_cnt < 65535) m_cnt++;
                if (m_cnt4 < 15) m_cnt4++;
            end
            if (t_br) begin
                m_valid = 0; m_instr = '0;
            end else if (!(hz || t_es)) begin
                m_pc = t_pc; m_instr = t_instr; m_valid = 1;
            end
        end
        #1;
    endtask

    function automatic logic [4:0] rand_rd();
        return ($urandom_range(0, 7) == 7) ? 5'd31 : 5'($urandom_range(0, 7));
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] ins;
        int k;
        ins = $urandom;
        ins[4:0]   = 5'($urandom_range(0, 7));
        ins[9:5]   = 5'($urandom_range(0, 7));
        ins[20:16] = 5'($urandom_range(0, 7));
        k = $urandom_range(0, 10);
        case (k)
            0: ins[31:21] = 11'b10101011000;
            1: ins[31:21] = 11'b11101011000;
            2: ins[31:21] = 11'b10001010000;
            3: ins[31:21] = 11'b10101010000;
            4: ins[31:21] = 11'b11001010000;
            5: ins[31:22] = 10'b1001000100;
            6: ins[31:21] = 11'b11111000010;
            7: ins[31:21] = 11'b11111000000;
            8: ins[31:24] = 8'b10110100;
            9: ins[31:26] = 6'b000101;
            default: ins = ins;
        endcase
        return ins;
    endfunction

    initial begin
        m_pc = '0; m_instr = '0; m_valid = 0; m_cnt = 0; m_cnt4 = 0;
        t_reset = 1'b1; t_pc = 64'd0; t_instr = ADDS_X1;
        t_br = 1'b0; t_es = 1'b0; t_mr = 1'b0; t_rd = 5'd0;
        @(posedge clk);
        #1;

        // reset held two cycles
        step();
        step();
        chk("rst_valid", 64'(bus16.id_valid), 64'd0);
        chk("rst_pcw",   64'(bus16.pc_write), 64'd1);
        chk("rst_cnt",   64'(bus16.hazard_count), 64'd0);
        t_reset = 1'b0;
        step();
        chk("t1_pc",    bus16.id_pc, 64'd0);
        chk("t1_valid", 64'(bus16.id_valid), 64'd1);

        // load-use on Rn of ADDS
        t_pc = 64'd4; t_mr = 1'b1; t_rd = 5'd2;
        #1;
        chk("t2_pcw",    64'(bus16.pc_write), 64'd0);
        chk("t2_bubble", 64'(bus16.id_bubble), 64'd1);
        step();
        chk("t2_hold", bus16.id_pc, 64'd0);
        chk("t2_cnt",  64'(bus16.hazard_count), 64'd1);
        t_mr = 1'b0;
        step();
        chk("t2_adv", bus16.id_pc, 64'd4);

        // destination-only match and XZR do not stall
        t_pc = 64'd8; t_mr = 1'b1; t_rd = 5'd1;
        #1;
        chk("t3_rd_pcw", 64'(bus16.pc_write), 64'd1);
        step();
        chk("t3_rd_cnt", 64'(bus16.hazard_count), 64'd1);
        t_pc = 64'd12; t_rd = 5'd31;
        #1;
        chk("t3_xzr_pcw", 64'(bus16.pc_write), 64'd1);
        step();
        chk("t3_xzr_cnt", 64'(bus16.hazard_count), 64'd1);

        // taken branch overrides the hazard
        t_rd = 5'd2; t_br = 1'b1;
        #1;
        chk("t4_pcw", 64'(bus16.pc_write), 64'd1);
        step();
        chk("t4_valid", 64'(bus16.id_valid), 64'd0);
        chk("t4_instr", 64'(bus16.id_instr), 64'd0);
        chk("t4_pc",    bus16.id_pc, 64'd12);
        chk("t4_cnt",   64'(bus16.hazard_count), 64'd1);

        // CBZ reads Rt; B reads nothing
        t_br = 1'b0; t_mr = 1'b0; t_instr = CBZ_X5; t_pc = 64'd16;
        step();
        t_mr = 1'b1; t_rd = 5'd5;
        #1;
        chk("t5_cbz_bub", 64'(bus16.id_bubble), 64'd1);
        chk("t5_cbz_pcw", 64'(bus16.pc_write), 64'd0);
        step();
        t_mr = 1'b0; t_instr = B_3; t_pc = 64'd20;
        step();
        t_mr = 1'b1; t_rd = 5'd0;
        #1;
        chk("t5_b_pcw", 64'(bus16.pc_write), 64'd1);
        chk("t5_b_bub", 64'(bus16.id_bubble), 64'd0);
        step();

        // saturation of the 4-bit counter, then external stall
        t_mr = 1'b0; t_instr = ADDS_X1; t_pc = 64'd24;
        step();
        t_mr = 1'b1; t_rd = 5'd2;
        repeat (20) step();
        chk("t6_cnt4",  64'(bus4.hazard_count), 64'd15);
        chk("t6_cnt16", 64'(bus16.hazard_count), 64'd22);
        t_mr = 1'b0; t_es = 1'b1; t_pc = 64'd28;
        repeat (2) step();
        chk("t6_es_pc",  bus16.id_pc, 64'd24);
        chk("t6_es_cnt", 64'(bus16.hazard_count), 64'd22);

        // reset asserted in the middle of a hazard stall
        t_es = 1'b0; t_mr = 1'b1; t_rd = 5'd2;
        step();
        t_reset = 1'b1;
        step();
        chk("rst_mid_valid", 64'(bus16.id_valid), 64'd0);
        chk("rst_mid_cnt",   64'(bus16.hazard_count), 64'd0);
        t_reset = 1'b0;

        // randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            t_reset = ($urandom_range(0, 59) == 0);
            t_pc    = {32'($urandom), 32'($urandom)} & ~64'd3;
            t_instr = rand_instr();
            t_br    = ($urandom_range(0, 7) == 0);
            t_es    = ($urandom_range(0, 7) == 0);
            t_mr    = 1'($urandom_range(0, 1));
            t_rd    = rand_rd();
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
